// File: rtl/rgb2gray.sv
// Streams a 128x128 RGB image from three plane memories and writes the luma plane:
// Y = (77R + 150G + 29B + 128) >> 8. The pipeline accepts one pixel per cycle and has three stages.
module rgb2gray (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [13:0] addr_r,
    output logic [13:0] addr_g,
    output logic [13:0] addr_b,
    input  logic [7:0]  rdata_r,
    input  logic [7:0]  rdata_g,
    input  logic [7:0]  rdata_b,
    output logic        wr_y,
    output logic [13:0] addr_y,
    output logic [7:0]  wdata_y,
    output logic        busy,
    output logic        done
);

    localparam logic [13:0] LAST_ADDR = 14'd16383;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t      state;
    logic [13:0] rd_addr;
    logic        rd_valid;   // rd_addr holds an address whose data arrives this cycle
    logic        s1_valid;
    logic [13:0] s1_tag;
    logic [15:0] prod_r, prod_g, prod_b;
    logic [15:0] sum_rnd;

    assign addr_r = rd_addr;
    assign addr_g = rd_addr;
    assign addr_b = rd_addr;

    // Worst case is 255*256 + 128 = 65408, so the rounded sum fits in 16 bits.
    assign sum_rnd = prod_r + prod_g + prod_b + 16'd128;

    // NOTE: product registers carry data only, and s1_valid qualifies them. Leaving them
    // out of reset keeps the reset tree small, and a stale value is never written.
    always_ff @(posedge clk) begin
        if (rd_valid) begin
            prod_r <= 16'(rdata_r) * 16'd77;
            prod_g <= 16'(rdata_g) * 16'd150;
            prod_b <= 16'(rdata_b) * 16'd29;
        end
    end

    // NOTE: every state register uses non-blocking assignment. Each stage then reads
    // its neighbour's value from before the clock edge, which is how the pipeline works.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_valid <= 1'b0;
            s1_valid <= 1'b0;
            s1_tag   <= '0;
            wr_y     <= 1'b0;
            addr_y   <= '0;
            wdata_y  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            s1_valid <= rd_valid;
            if (rd_valid)
                s1_tag <= rd_addr;
            wr_y <= s1_valid;
            if (s1_valid) begin
                addr_y  <= s1_tag;
                wdata_y <= sum_rnd[15:8];
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        rd_addr  <= '0;
                        rd_valid <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (rd_addr == LAST_ADDR) begin
                        state    <= FLUSH;
                        rd_addr  <= '0;
                        rd_valid <= 1'b0;
                    end else begin
                        rd_addr <= rd_addr + 14'd1;
                    end
                end
                FLUSH: begin
                    if (wr_y && addr_y == LAST_ADDR) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
